// File: rtl/jtroc_snd_if_if.sv
// Sound-side bus between the main-CPU latch and the sound Z80.
// master: drives latch/strobes and reads IRQ/status/timer/gain; slave: the stage.
interface jtroc_snd_if_if;
  logic       snd_cen;
  logic [7:0] snd_latch;
  logic       snd_on;
  logic       mute;
  logic       latch_rd;
  logic       irq_ack;
  logic       irq_n;
  logic [7:0] cmd_dout;
  logic       ovf;
  logic [3:0] timer_dout;
  logic [7:0] gain;

  modport master (
    output snd_cen, snd_latch, snd_on,
    output mute, latch_rd, irq_ack,
    input  irq_n, cmd_dout, ovf,
    input  timer_dout, gain
  );

  modport slave (
    input  snd_cen, snd_latch, snd_on,
    input  mute, latch_rd, irq_ack,
    output irq_n, cmd_dout, ovf,
    output timer_dout, gain
  );
endinterface

// File: rtl/jtroc_snd_if.sv
// Sound interface stage: command capture, edge IRQ, overrun, timer, gain ramp.
// Ports: clk, rstn (async low), bus (slave side of jtroc_snd_if_if).
module jtroc_snd_if #(
  parameter int TDIV  = 1024,
  parameter int GSTEP = 1
) (
  input  logic          clk,
  input  logic          rstn,
  jtroc_snd_if_if.slave bus
);

  localparam int PW = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TDIV - 1);
  localparam logic [7:0] GS = 8'(GSTEP);
  localparam logic [7:0] GTOP = 8'hff - GS;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } st_t;

  st_t st_q, st_nx;

  logic          on_l;
  logic          rise;
  logic          ack;
  logic          rd;
  logic [7:0]    cmd_q;
  logic          ovf_q;
  logic [PW-1:0] pre_q;
  logic [3:0]    tmr_q;
  logic [7:0]    gain_q;
  logic [7:0]    gain_nx;

  assign rise = bus.snd_on & ~on_l;
  assign ack  = bus.irq_ack & bus.snd_cen;
  assign rd   = bus.latch_rd & bus.snd_cen;

  // A rise always re-arms the IRQ, so it beats a same-clk ack.
  always_comb begin
    st_nx = st_q;
    unique case (st_q)
      IDLE: if (rise) st_nx = PEND;
      PEND: if (ack && !rise) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    gain_nx = gain_q;
    if (bus.snd_cen) begin
      if (bus.mute)
        gain_nx = (gain_q < GS) ? 8'd0 : gain_q - GS;
      else
        gain_nx = (gain_q > GTOP) ? 8'hff : gain_q + GS;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= IDLE;
      on_l   <= 1'b0;
      cmd_q  <= 8'd0;
      ovf_q  <= 1'b0;
      pre_q  <= '0;
      tmr_q  <= 4'd0;
      gain_q <= 8'd0;
    end else begin
      st_q   <= st_nx;
      on_l   <= bus.snd_on;
      gain_q <= gain_nx;
      if (rise)
        cmd_q <= bus.snd_latch;
      // Overrun only when a pending IRQ is not being acked; set beats clear.
      if (rise && st_q == PEND && !ack)
        ovf_q <= 1'b1;
      else if (rd)
        ovf_q <= 1'b0;
      if (bus.snd_cen) begin
        if (pre_q == PMAX) begin
          pre_q <= '0;
          tmr_q <= tmr_q + 4'd1;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  assign bus.irq_n      = (st_q == IDLE);
  assign bus.cmd_dout   = cmd_q;
  assign bus.ovf        = ovf_q;
  assign bus.timer_dout = tmr_q;
  assign bus.gain       = gain_q;

endmodule

// File: tb/tb_jtroc_snd_if.sv
// Bench for jtroc_snd_if: directed plan plus random traffic vs a count model.
// Model tracks pending/overrun flags, total cen pulses and saturating gain.
module tb_jtroc_snd_if;

  localparam int TD = 4;
  localparam int GS = 16;

  logic clk;
  logic rstn;
  int total;
  int bad;

  jtroc_snd_if_if bus ();

  jtroc_snd_if #(
    .TDIV (TD),
    .GSTEP(GS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit m_on;
  bit m_pend;
  bit m_ovf;
  int m_cmd;
  int m_ncen;
  int m_gain;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_on = 0; m_pend = 0; m_ovf = 0;
    m_cmd = 0; m_ncen = 0; m_gain = 0;
  endtask

  task automatic m_update();
    bit rise, ack, rd;
    if (!rstn) begin
      m_reset();
      return;
    end
    rise = bus.snd_on && !m_on;
    m_on = bus.snd_on;
    ack = bus.irq_ack && bus.snd_cen;
    rd = bus.latch_rd && bus.snd_cen;
    if (rise) m_cmd = bus.snd_latch;
    if (m_pend && rise && !ack) m_ovf = 1;
    else if (rd) m_ovf = 0;
    if (rise) m_pend = 1;
    else if (ack) m_pend = 0;
    if (bus.snd_cen) begin
      m_ncen++;
      if (bus.mute) m_gain = (m_gain < GS) ? 0 : m_gain - GS;
      else m_gain = (m_gain + GS > 255) ? 255 : m_gain + GS;
    end
  endtask

  task automatic chk_all();
    chk("irq_n", 32'(bus.irq_n), 32'(!m_pend));
    chk("cmd", 32'(bus.cmd_dout), 32'(m_cmd));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("timer", 32'(bus.timer_dout), 32'((m_ncen / TD) % 16));
    chk("gain", 32'(bus.gain), 32'(m_gain));
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
    chk_all();
    bus.snd_cen = 0;
    bus.latch_rd = 0;
    bus.irq_ack = 0;
  endtask

  task automatic do_reset(int n);
    rstn = 0;
    bus.snd_on = 0;
    for (int i = 0; i < n; i++) tick();
    rstn = 1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 0;
    bus.snd_cen = 0;
    bus.snd_latch = 0;
    bus.snd_on = 0;
    bus.mute = 0;
    bus.latch_rd = 0;
    bus.irq_ack = 0;
    m_reset();

    do_reset(5);
    chk("rst_irq", 32'(bus.irq_n), 32'd1);
    chk("rst_cmd", 32'(bus.cmd_dout), 32'd0);
    chk("rst_gain", 32'(bus.gain), 32'd0);

    bus.snd_latch = 8'h3c; bus.snd_on = 1; tick();
    chk("edge_cmd", 32'(bus.cmd_dout), 32'h3c);
    chk("edge_irq", 32'(bus.irq_n), 32'd0);
    chk("edge_ovf", 32'(bus.ovf), 32'd0);

    bus.irq_ack = 1; bus.snd_cen = 1; tick();
    chk("ack_irq", 32'(bus.irq_n), 32'd1);

    bus.snd_on = 0; tick();
    bus.snd_latch = 8'h55; bus.snd_on = 1; tick();
    chk("re_irq", 32'(bus.irq_n), 32'd0);
    chk("re_cmd", 32'(bus.cmd_dout), 32'h55);

    bus.snd_on = 0; tick();
    bus.snd_latch = 8'ha1; bus.snd_on = 1; tick();
    chk("ovr_ovf", 32'(bus.ovf), 32'd1);
    chk("ovr_cmd", 32'(bus.cmd_dout), 32'ha1);
    chk("ovr_irq", 32'(bus.irq_n), 32'd0);

    bus.latch_rd = 1; bus.snd_cen = 1; tick();
    chk("rd_ovf", 32'(bus.ovf), 32'd0);

    bus.snd_on = 0; tick();
    bus.snd_on = 1; bus.irq_ack = 1; bus.snd_cen = 1; tick();
    chk("co_ack_irq", 32'(bus.irq_n), 32'd0);
    chk("co_ack_ovf", 32'(bus.ovf), 32'd0);

    bus.snd_on = 0; tick();
    bus.snd_on = 1; bus.latch_rd = 1; bus.snd_cen = 1; tick();
    chk("co_rd_ovf", 32'(bus.ovf), 32'd1);

    // timer and gain from a fresh reset
    do_reset(2);
    bus.mute = 0;
    for (int i = 1; i <= 64; i++) begin
      if (i == 17) bus.mute = 1;
      bus.snd_cen = 1; tick();
      if (i == 15) chk("g_240", 32'(bus.gain), 32'd240);
      if (i == 16) chk("g_sat", 32'(bus.gain), 32'd255);
      if (i == 31) chk("g_15", 32'(bus.gain), 32'd15);
      if (i == 32) chk("g_0", 32'(bus.gain), 32'd0);
      if (i == 40) chk("g_hold0", 32'(bus.gain), 32'd0);
      if (i % 4 == 0 && i < 64)
        chk("t_step", 32'(bus.timer_dout), 32'(i / 4));
      tick();
    end
    chk("t_wrap", 32'(bus.timer_dout), 32'd0);

    bus.mute = 0;
    for (int i = 0; i < 6; i++) begin
      bus.snd_cen = 1; tick();
    end
    chk("t_mid", 32'(bus.timer_dout), 32'd1);
    #2 rstn = 0;
    #1;
    chk("arst_timer", 32'(bus.timer_dout), 32'd0);
    chk("arst_gain", 32'(bus.gain), 32'd0);
    m_reset();
    do_reset(2);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) bus.snd_on = ~bus.snd_on;
      bus.snd_latch = 8'($urandom);
      bus.snd_cen = ($urandom_range(0, 2) == 0);
      bus.irq_ack = ($urandom_range(0, 3) == 0);
      bus.latch_rd = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) bus.mute = ~bus.mute;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtroc_snd_if.md
Name: jtroc_snd_if

Overview:
- Sound-side interface stage directly downstream of the main-CPU block.
- Consumes the main CPU's sound latch, sound-trigger bit and mute bit, then presents to the sound Z80:
  - a stable command byte
  - an edge-triggered IRQ with acknowledge handling
  - an overrun status flag
  - the free-running 4-bit sound timer
- Also produces a ramped mute gain for the mixer, so mute on/off does not click.

Parameters:
- TDIV, 1024: number of snd_cen pulses per timer increment (range 2..65536).
- GSTEP, 1: gain ramp step per snd_cen pulse, 8-bit unsigned, must be 1..255.

Ports:
- clk  in  1  system clock (24 MHz).
- rstn  in  1  reset; asynchronous, active low.
- snd_cen  in  1  sound-CPU clock enable, one clk wide.
- snd_latch  in  8  command byte from the main CPU.
- snd_on  in  1  trigger bit from the main CPU; a rising edge requests an interrupt.
- mute  in  1  mute request from the main CPU.
- latch_rd  in  1  sound-CPU read strobe of the command register; one clk wide, qualified by snd_cen.
- irq_ack  in  1  Z80 interrupt-acknowledge cycle; one clk wide, qualified by snd_cen.
- irq_n  out  1  Z80 IRQ, active low.
- cmd_dout  out  8  captured command byte.
- ovf  out  1  sticky overrun flag.
- timer_dout  out  4  free-running timer value.
- gain  out  8  mixer gain, 0 = silent, 255 = full.

Behaviour:
- Reset (rstn low, asynchronous) forces these values; all registers resume counting from them after reset release:
  - irq_n = 1
  - cmd_dout = 0
  - ovf = 0
  - timer_dout = 0
  - gain = 0
  - snd_on history register = 0
  - prescaler = 0
- Edge detect:
  - on_l <= snd_on every clk; rise = snd_on & ~on_l.
  - Evaluated every clk, not gated by snd_cen.
  - snd_on held high after reset release counts as a rise on the first clk.
- Command capture:
  - On rise, cmd_dout <= snd_latch in the same clk; visible at the next clk.
  - snd_latch changes without a rise are ignored.
- IRQ state machine, two states:
  - IDLE (irq_n = 1): rise -> PEND.
  - PEND (irq_n = 0): (irq_ack & snd_cen) -> IDLE.
  - Rise in PEND: ovf <= 1, stay in PEND; cmd_dout is still overwritten with the new byte.
  - Rise and ack in the same clk: rise wins, state stays PEND, ovf is not set.
  - irq_ack while IDLE: no effect.
- Overrun flag:
  - ovf clears on (latch_rd & snd_cen).
  - If a rise that would set ovf coincides with the clearing read, set wins.
- Timer:
  - A prescaler counts snd_cen pulses 0..TDIV-1.
  - On the pulse where it equals TDIV-1, it wraps to 0 and timer_dout increments, wrapping 15 -> 0.
  - Prescaler and timer are unaffected by every input other than snd_cen and rstn.
- Gain ramp, on each snd_cen:
  - mute = 1: gain <= (gain < GSTEP) ? 0 : gain - GSTEP.
  - mute = 0: gain <= (gain > 255-GSTEP) ? 255 : gain + GSTEP.
  - Saturating arithmetic; no wrap. With no snd_cen, gain holds.
  - After reset gain starts at 0 and ramps up with mute = 0, giving a soft start.
- Latency: outputs are registered, one clk after the qualifying input.
- No combinational path from any input to any output.

Test Plan:
- Reset then edge: rstn low 5 clk, release; snd_latch = 8'h3C, raise snd_on -> next clk cmd_dout = 8'h3C, irq_n = 0, ovf = 0.
- Acknowledge: irq_ack pulse with snd_cen -> irq_n = 1 the next clk. Drop and raise snd_on again with snd_latch = 8'h55 -> irq_n = 0, cmd_dout = 8'h55.
- Overrun: while irq_n = 0, give a second rise with snd_latch = 8'hA1 -> ovf = 1, cmd_dout = 8'hA1, irq_n stays 0. Then latch_rd with snd_cen -> ovf = 0.
- Coincidence: rise and irq_ack in the same clk -> irq_n = 0 and ovf = 0. Rise and latch_rd in the same clk while pending -> ovf = 1.
- Timer with TDIV = 4: 64 snd_cen pulses after reset -> timer_dout = 0 (wrapped), having stepped 1 every 4 pulses. Assert rstn low mid-count -> timer_dout = 0 immediately, asynchronously.
- Gain with GSTEP = 16, mute = 0: after 16 snd_cen pulses gain = 255 (saturated from 240+16). Set mute = 1: after 15 pulses gain = 15, after one more gain = 0, and it stays 0.
